// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// The result is computed on Start, held in a pending register, and written to HI/LO when the busy countdown expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;

  mdu_op_e            op;
  logic               is_arith;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        div_b;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic [63:0]        result;

  assign op       = mdu_op_e'(MDUop);
  assign is_arith = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

  // The divisor is forced to 1 for B==0 and for the signed overflow case; A/1 is exactly
  // the required 0x80000000 / -1 result, and the simulator never sees an undefined division.
  assign div_zero = (B == 32'd0);
  assign div_ovf  = (op == OP_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_b    = (div_zero || div_ovf) ? 32'd1 : B;

  assign prod_s = 64'($signed(A)) * 64'($signed(B));
  assign prod_u = 64'(A) * 64'(B);
  assign quo_s  = $signed(A) / $signed(div_b);
  assign rem_s  = $signed(A) % $signed(div_b);
  assign quo_u  = A / div_b;
  assign rem_u  = A % div_b;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    result = {hi_q, lo_q};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   if (!div_zero) result = {rem_s, quo_s};
      OP_DIVU:  if (!div_zero) result = {rem_u, quo_u};
      default:  result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (Start && is_arith) begin
          {pend_hi_d, pend_lo_d} = result;
          cnt_d   = ((op == OP_MULT) || (op == OP_MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = RUN;
        end else if (op == OP_MTHI) begin
          hi_d = A;
        end else if (op == OP_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Out  = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: busy timing, MULT/MULTU/DIV/DIVU results, MTHI/MTLO/MFHI/MFLO,
// divide by zero, Start during Busy and reset during an in-flight divide.
module tb_e_mdu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  MDUop;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO, Out;

  int checks = 0;
  int errors = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDUop(MDUop), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse Start for one cycle, then count cycles until Busy drops (bounded).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    int cnt;
    MDUop = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0; MDUop = 4'd0;
    cnt = 0;
    while (Busy && cnt < 50) begin
      tick();
      cnt++;
    end
    check({tag, "_cycles"}, 32'(cnt), 32'(n));
  endtask

  initial begin
    int cnt;
    Reset = 1'b0; Start = 1'b0; MDUop = 4'd0; A = '0; B = '0;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_out", Out, 32'h0);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    run_op("divu", 4'd4, 32'd100, 32'd7, 10);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // MTHI/MTLO in IDLE, without Start.
    MDUop = 4'd5; A = 32'h1234; tick();
    check("mthi_hi", HI, 32'h1234);
    check("mthi_busy", 32'(Busy), 32'h0);
    MDUop = 4'd6; A = 32'h5678; tick();
    MDUop = 4'd0;
    check("mtlo_lo", LO, 32'h5678);
    check("mtlo_hi_kept", HI, 32'h1234);

    run_op("divu0", 4'd4, 32'd5, 32'd0, 10);
    check("divu0_hi", HI, 32'h1234);
    check("divu0_lo", LO, 32'h5678);
    run_op("div0", 4'd3, 32'hFFFF_FFF9, 32'd0, 10);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);

    MDUop = 4'd7; #1;
    check("mfhi_out", Out, 32'h1234);
    MDUop = 4'd8; #1;
    check("mflo_out", Out, 32'h5678);
    MDUop = 4'd9; #1;
    check("op9_out", Out, 32'h0);
    MDUop = 4'd0; #1;
    check("nop_out", Out, 32'h0);

    // Start with a non-arithmetic op has no effect.
    MDUop = 4'd7; Start = 1'b1; tick();
    Start = 1'b0; MDUop = 4'd0;
    check("start_mf_busy", 32'(Busy), 32'h0);

    // DIVU 200/3 with a stray MULT Start and an MTHI arriving mid-run.
    MDUop = 4'd4; A = 32'd200; B = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0; MDUop = 4'd0;
    cnt = 0;
    while (Busy && cnt < 50) begin
      if (cnt == 2) begin
        MDUop = 4'd1; A = 32'd2; B = 32'd2; Start = 1'b1;
      end else if (cnt == 4) begin
        MDUop = 4'd5; A = 32'hDEAD_BEEF; Start = 1'b0;
      end else begin
        MDUop = 4'd0; Start = 1'b0;
      end
      tick();
      cnt++;
      if (cnt == 6) check("run_hi_held", HI, 32'h1234);
    end
    MDUop = 4'd0; Start = 1'b0;
    check("stray_cycles", 32'(cnt), 32'd10);
    check("stray_lo", LO, 32'd66);
    check("stray_hi", HI, 32'd2);
    tick();
    check("stray_after_busy", 32'(Busy), 32'h0);

    // Reset on the 4th Busy cycle of a DIV discards it.
    MDUop = 4'd3; A = 32'd50; B = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0; MDUop = 4'd0;
    tick(); tick(); tick();
    check("rst_mid_busy_pre", 32'(Busy), 32'h1);
    Reset = 1'b0;
    tick();
    check("rst_mid_busy", 32'(Busy), 32'h0);
    check("rst_mid_hi", HI, 32'h0);
    check("rst_mid_lo", LO, 32'h0);
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("rst_mid_busy_later", 32'(Busy), 32'h0);
    check("rst_mid_lo_later", LO, 32'h0);
    check("rst_mid_hi_later", HI, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
